// File: rtl/csel_serial_subtractor.sv
// rtl/csel_serial_subtractor.sv - multi-cycle carry-select subtractor, one 4-bit slice per clock
//
// Computes diff = a - b - bin over WIDTH bits, lowest nibble first. Each cycle
// both slice results (borrow-in 0 and 1) are formed; the registered borrow
// picks one.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, bin           minuend, subtrahend, borrow-in
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   diff, bout          (a - b - bin) mod 2^WIDTH, unsigned borrow-out
//   ovf, zero           signed overflow, diff == 0

module csel_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("csel_serial_subtractor: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sh;      // operands shift right one nibble per slice
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] wdiff;     // result fills from the top, lands in place after NIB slices
    logic             a_msb;     // sign bits kept for the overflow decision
    logic             b_msb;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic [4:0]        s0;
    logic [4:0]        s1;
    logic [4:0]        sel;
    logic [WIDTH+3:0]  cat;
    logic [WIDTH-1:0]  next_wdiff;
    logic              last;

    always_comb begin
        // a - b - borrow == a + ~b + (1 - borrow); bit 4 is carry = no borrow
        s0         = {1'b0, a_sh[3:0]} + {1'b0, ~b_sh[3:0]} + 5'd1;
        s1         = {1'b0, a_sh[3:0]} + {1'b0, ~b_sh[3:0]};
        sel        = borrow ? s1 : s0;
        cat        = {sel[3:0], wdiff};
        next_wdiff = cat[WIDTH+3:4];
        last       = (cnt == CW'(NIB - 1));
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            wdiff  <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        borrow <= bin;
                        wdiff  <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    wdiff  <= next_wdiff;
                    borrow <= ~sel[4];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff  <= next_wdiff;
                        bout  <= ~sel[4];
                        ovf   <= (a_msb != b_msb) && (next_wdiff[WIDTH-1] != a_msb);
                        zero  <= (next_wdiff == '0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csel_serial_subtractor.sv
// tb/tb_csel_serial_subtractor.sv - directed self-checking bench for csel_serial_subtractor

module tb_csel_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int checks;
    int errors;

    csel_serial_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one operation, then wait (bounded) for out_valid and check latency.
    task automatic start_and_wait(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin);
        int lat;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'hA5A5;   // post-capture changes must not matter
        b        = 16'h5A5A;
        bin      = ~tbin;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
    endtask

    task automatic check_result(input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
        check("diff", 32'(diff), 32'(ed));
        check("bout", 32'(bout), 32'(eb));
        check("ovf",  32'(ovf),  32'(eo));
        check("zero", 32'(zero), 32'(ez));
    endtask

    // Full operation with out_ready held high: result is taken on the next edge.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                         input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
        start_and_wait(ta, tb_v, tbin);
        check_result(ed, eb, eo, ez);
        @(posedge clk);
        #1;
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
        check("diff_held_after_handshake", 32'(diff), 32'(ed));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check_result(16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        do_op(16'h00F0, 16'h00EF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

        // Backpressure: result must stay put, new requests ignored.
        out_ready = 1'b0;
        start_and_wait(16'h0005, 16'h0003, 1'b0);
        check_result(16'h0002, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2) == 0;
            a        = 16'h1111 * 16'(i + 1);
            b        = 16'h0101;
            bin      = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_diff",      32'(diff),      32'h0002);
            check("bp_flags",     32'({bout, ovf, zero}), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("bp_no_capture_out_valid", 32'(out_valid), 32'd0);
        check("bp_no_capture_diff",      32'(diff),      32'h0002);

        // Reset two cycles into RUN aborts the operation.
        check("pre_abort_in_ready", 32'(in_ready), 32'd1);
        a        = 16'h4321;
        b        = 16'h1234;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check_result(16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_abort_in_ready",  32'(in_ready),  32'd1);
        check("post_abort_out_valid", 32'(out_valid), 32'd0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
